// File: rtl/spi_tx_rr_arbiter.sv
// Round-robin arbiter sharing one SPI mode-3 byte transmitter among NUM_REQ requesters.
// Optional build macro SPI_ARB_LOCK_EN adds In_lock for multi-byte bursts by one owner.
module spi_tx_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 In_clk,
  input  logic                 In_rst,
  input  logic [NUM_REQ-1:0]   In_req,
  input  logic [8*NUM_REQ-1:0] In_data,
  output logic [NUM_REQ-1:0]   Out_grant,
  output logic [NUM_REQ-1:0]   Out_ack,
  output logic                 Out_err,
  output logic                 Out_busy,
  output logic                 Out_tx_req,
  output logic [7:0]           Out_tx_data,
  input  logic                 In_tx_busy
`ifdef SPI_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]   In_lock
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_q;
  logic [TMR_W-1:0]   timer;
  logic               err_flag;
  logic               lock_held;

  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [PTR_W-1:0]   pick;
  logic               pick_valid;
  logic [7:0]         sel_data;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] lock_bits;

`ifdef SPI_ARB_LOCK_EN
  assign lock_bits = In_lock;
`else
  assign lock_bits = '0;
`endif

  // Scan from rr_ptr upward with wrap; the first active request wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && In_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end

    // A held lock restricts arbitration to the previous owner.
    pick       = lock_held ? win_q : win_idx;
    pick_valid = lock_held ? In_req[win_q] : win_found;
    sel_data   = In_data[{pick, 3'b000} +: 8];
    next_ptr   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      win_q       <= '0;
      timer       <= '0;
      err_flag    <= 1'b0;
      lock_held   <= 1'b0;
      Out_grant   <= '0;
      Out_ack     <= '0;
      Out_err     <= 1'b0;
      Out_busy    <= 1'b0;
      Out_tx_req  <= 1'b0;
      Out_tx_data <= '0;
    end else begin
      Out_ack <= '0;
      Out_err <= 1'b0;

      case (state)
        IDLE: begin
          if (lock_held && !In_req[win_q]) begin
            // Owner walked away from its lock; return to normal rotation.
            lock_held <= 1'b0;
            Out_grant <= '0;
          end else if (pick_valid && !In_tx_busy) begin
            win_q       <= pick;
            Out_grant   <= NUM_REQ'(1) << pick;
            Out_tx_data <= sel_data;
            Out_tx_req  <= 1'b1;
            Out_busy    <= 1'b1;
            timer       <= '0;
            state       <= START;
          end
        end

        START: begin
          if (In_tx_busy) begin
            Out_tx_req <= 1'b0;
            state      <= XFER;
          end else if (timer == TMR_LAST) begin
            Out_tx_req <= 1'b0;
            err_flag   <= 1'b1;
            state      <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        XFER: begin
          if (!In_tx_busy) begin
            state <= DONE;
          end
        end

        DONE: begin
          Out_ack  <= Out_grant;
          Out_err  <= err_flag;
          err_flag <= 1'b0;
          Out_busy <= 1'b0;
          state    <= IDLE;
          if (lock_bits[win_q]) begin
            lock_held <= 1'b1;
          end else begin
            lock_held <= 1'b0;
            Out_grant <= '0;
            rr_ptr    <= next_ptr;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_rr_arbiter.sv
// Self-checking bench for spi_tx_rr_arbiter: table-driven single requests, hand-written
// round-robin / timeout / reset / lock sequences, and a byte scoreboard fed by a transmitter model.
module tb_spi_tx_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct {
    int           idx;
    logic [7:0]   data;
    logic [N-1:0] exp_grant;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           err;
  logic           busy;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           tx_model_en = 1'b1;
  int             xfer_len = 3;
  int             tx_cnt = 0;
`ifdef SPI_ARB_LOCK_EN
  logic [N-1:0]   lock = '0;
`endif

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  spi_tx_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .In_clk      (clk),
    .In_rst      (rst),
    .In_req      (req),
    .In_data     (data),
    .Out_grant   (grant),
    .Out_ack     (ack),
    .Out_err     (err),
    .Out_busy    (busy),
    .Out_tx_req  (tx_req),
    .Out_tx_data (tx_data),
    .In_tx_busy  (tx_busy)
`ifdef SPI_ARB_LOCK_EN
    ,
    .In_lock     (lock)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: accepts a byte on tx_req, stays busy xfer_len cycles, pops the scoreboard.
  always @(negedge clk) begin
    if (tx_busy) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt <= 0) tx_busy = 1'b0;
    end else if (tx_model_en && tx_req === 1'b1) begin
      tx_busy = 1'b1;
      tx_cnt  = xfer_len;
      if (exp_q.size() == 0) check("tx_byte_unexpected", 32'(exp_q.size()), 32'd1);
      else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns the first non-zero ack within a cycle budget; zero on expiry (fails the caller's check).
  task automatic wait_ack(output logic [N-1:0] a, output logic e);
    a = '0;
    e = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ack !== '0) begin
        a = ack;
        e = err;
        break;
      end
    end
    if (a == '0) $display("FAIL ack_wait: got no ack within 200 cycles, required one");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

  initial begin : main
    vec_t         vecs[5];
    logic [N-1:0] rr_exp[5];
    logic [N-1:0] a;
    logic         e;
    int           cnt;
    logic         seen_req;

    vecs[0] = '{2, 8'h12, 4'b0100};
    vecs[1] = '{0, 8'h01, 4'b0001};
    vecs[2] = '{3, 8'hFF, 4'b1000};
    vecs[3] = '{1, 8'h00, 4'b0010};
    vecs[4] = '{2, 8'hA5, 4'b0100};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with every requester active: everything quiet.
    rst = 1'b1;
    req = 4'b1111;
    data = 32'hDEADBEEF;
    tick(); tick(); tick();
    check("rst_grant",   32'(grant),   32'd0);
    check("rst_ack",     32'(ack),     32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_tx_req",  32'(tx_req),  32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    req = '0;
    rst = 1'b0;
    tick();

    // Table-driven single requests.
    for (int v = 0; v < 5; v++) begin
      data[8*vecs[v].idx +: 8] = vecs[v].data;
      req = '0;
      req[vecs[v].idx] = 1'b1;
      exp_q.push_back(vecs[v].data);
      tick();
      check("single_tx_req",  32'(tx_req),  32'd1);
      check("single_tx_data", 32'(tx_data), 32'(vecs[v].data));
      check("single_grant",   32'(grant),   32'(vecs[v].exp_grant));
      check("single_busy",    32'(busy),    32'd1);
      wait_ack(a, e);
      req = '0;
      check("single_ack", 32'(a), 32'(vecs[v].exp_grant));
      check("single_err", 32'(e), 32'd0);
      tick();
      check("single_idle_grant", 32'(grant), 32'd0);
      check("single_ack_pulse",  32'(ack),   32'd0);
    end

    // Round-robin with all four requesting from rr_ptr=0.
    do_reset();
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, e);
      if (k == 4) req = '0;
      check("rr_ack", 32'(a), 32'(rr_exp[k]));
      check("rr_err", 32'(e), 32'd0);
    end
    tick();

    // Timeout: transmitter never goes busy.
    tx_model_en = 1'b0;
    data[15:8] = 8'h3C;
    req = 4'b0010;
    tick();
    check("to_tx_req_latency", 32'(tx_req), 32'd1);
    cnt = 0;
    while (tx_req === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("to_tx_req_cycles", 32'(cnt), 32'(TO));
    tick();
    check("to_ack", 32'(ack), 32'b0010);
    check("to_err", 32'(err), 32'd1);
    req = '0;
    tick();
    check("to_ack_pulse", 32'(ack), 32'd0);
    check("to_err_pulse", 32'(err), 32'd0);
    tx_model_en = 1'b1;

    // Reset in the middle of a long transfer; the transmitter stays busy across it.
    xfer_len = 20;
    data[31:24] = 8'h9E;
    req = 4'b1000;
    exp_q.push_back(8'h9E);
    tick();
    check("mid_tx_req", 32'(tx_req), 32'd1);
    repeat (4) tick();
    check("mid_busy",  32'(busy),  32'd1);
    check("mid_grant", 32'(grant), 32'b1000);
    rst = 1'b1;
    #1;
    check("mid_rst_grant",   32'(grant),   32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    data[31:24] = 8'h4B;
    exp_q.push_back(8'h4B);
    tick();
    rst = 1'b0;
    xfer_len = 3;
    seen_req = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (tx_busy) seen_req = seen_req | tx_req;
      else break;
    end
    check("mid_wait_no_req",  32'(seen_req), 32'd0);
    check("mid_after_tx_req", 32'(tx_req),   32'd1);
    check("mid_after_data",   32'(tx_data),  32'h4B);
    wait_ack(a, e);
    req = '0;
    check("mid_after_ack", 32'(a), 32'b1000);
    tick();

`ifdef SPI_ARB_LOCK_EN
    // Locked owner 0 sends three bytes before requester 3 gets a turn.
    do_reset();
    data = '0;
    data[7:0]   = 8'h55;
    data[31:24] = 8'hD3;
    lock = 4'b0001;
    req  = 4'b1001;
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    exp_q.push_back(8'h77); exp_q.push_back(8'hD3);
    wait_ack(a, e);
    data[7:0] = 8'h66;
    check("lock_ack1", 32'(a), 32'b0001);
    check("lock_grant_held", 32'(grant), 32'b0001);
    wait_ack(a, e);
    data[7:0] = 8'h77;
    lock = '0;
    check("lock_ack2", 32'(a), 32'b0001);
    wait_ack(a, e);
    req[0] = 1'b0;
    check("lock_ack3", 32'(a), 32'b0001);
    wait_ack(a, e);
    req = '0;
    check("lock_ack4", 32'(a), 32'b1000);
    tick();
`endif

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
